// File: rtl/ysyx_24110006_inst_enc.sv
// RV32I instruction encoder: takes decoded fields plus a full-width immediate
// and assembles the 32-bit word in a 2-stage valid/ready pipeline.
module ysyx_24110006_inst_enc (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic        o_err,
  output logic [15:0] o_cnt_ok,
  output logic [15:0] o_cnt_err
);

  localparam logic [2:0]  FMT_R = 3'd0;
  localparam logic [2:0]  FMT_I = 3'd1;
  localparam logic [2:0]  FMT_S = 3'd2;
  localparam logic [2:0]  FMT_B = 3'd3;
  localparam logic [2:0]  FMT_U = 3'd4;
  localparam logic [2:0]  FMT_J = 3'd5;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_req_t;

  enc_req_t    s1_q, req_in;
  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic [15:0] cnt_ok_q, cnt_err_q;
  logic        s2_ready, accept, advance, out_hs;

  assign s2_ready = !s2_valid_q || i_ready;
  assign o_ready  = !s1_valid_q || s2_ready;
  assign accept   = i_valid && o_ready;
  assign advance  = s1_valid_q && s2_ready;
  assign out_hs   = s2_valid_q && i_ready;

  assign req_in = '{fmt: i_fmt, opcode: i_opcode, funct3: i_funct3, funct7: i_funct7,
                    rd: i_rd, rs1: i_rs1, rs2: i_rs2, imm: i_imm};

  // S1 empties when its content moves on and nothing new arrives behind it
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (o_ready) s1_valid_d = i_valid;
    s2_valid_d = s2_valid_q;
    if (s2_ready) s2_valid_d = s1_valid_q;
  end

  // Immediate range checks: the bits above the encodable field must be a
  // pure sign extension of it.
  logic sx11, sx12, sx20;
  assign sx11 = (&s1_q.imm[31:11]) | ~(|s1_q.imm[31:11]);
  assign sx12 = (&s1_q.imm[31:12]) | ~(|s1_q.imm[31:12]);
  assign sx20 = (&s1_q.imm[31:20]) | ~(|s1_q.imm[31:20]);

  always_comb begin
    err_d = 1'b0;
    case (s1_q.fmt)
      FMT_R:        err_d = 1'b0;
      FMT_I, FMT_S: err_d = !sx11;
      FMT_B:        err_d = !sx12 || s1_q.imm[0];
      FMT_U:        err_d = |s1_q.imm[11:0];
      FMT_J:        err_d = !sx20 || s1_q.imm[0];
      default:      err_d = 1'b1;
    endcase
  end

  // Only the fields a format actually carries reach the word
  always_comb begin
    inst_d = NOP;
    case (s1_q.fmt)
      FMT_R: inst_d = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      FMT_I: inst_d = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      FMT_S: inst_d = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                       s1_q.imm[4:0], s1_q.opcode};
      FMT_B: inst_d = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                       s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
      FMT_U: inst_d = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
      FMT_J: inst_d = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
                       s1_q.rd, s1_q.opcode};
      default: inst_d = NOP;
    endcase
    if (err_d) inst_d = NOP;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      inst_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) s1_q <= req_in;
      if (advance) begin
        inst_q <= inst_d;
        err_q  <= err_d;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else if (out_hs) begin
      if (err_q) begin
        if (cnt_err_q != 16'hFFFF) cnt_err_q <= cnt_err_q + 16'd1;
      end else begin
        if (cnt_ok_q != 16'hFFFF) cnt_ok_q <= cnt_ok_q + 16'd1;
      end
    end
  end

  assign o_valid   = s2_valid_q;
  assign o_inst    = inst_q;
  assign o_err     = err_q;
  assign o_cnt_ok  = cnt_ok_q;
  assign o_cnt_err = cnt_err_q;

endmodule

// File: tb/tb_ysyx_24110006_inst_enc.sv
// Directed bench for the instruction encoder; expected words are queued at
// acceptance and compared in order as results are consumed.
module tb_ysyx_24110006_inst_enc;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_fmt = '0;
  logic [6:0]  i_opcode = '0;
  logic [2:0]  i_funct3 = '0;
  logic [6:0]  i_funct7 = '0;
  logic [4:0]  i_rd = '0, i_rs1 = '0, i_rs2 = '0;
  logic [31:0] i_imm = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_inst;
  logic        o_err;
  logic [15:0] o_cnt_ok, o_cnt_err;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];
  logic [32:0] mon_exp;

  ysyx_24110006_inst_enc dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_fmt(i_fmt), .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7(i_funct7),
    .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
    .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst), .o_err(o_err),
    .o_cnt_ok(o_cnt_ok), .o_cnt_err(o_cnt_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Results are consumed at the falling edge where inputs are stable
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) chk("unexpected_result", {31'b0, o_valid}, 32'd0);
      else begin
        mon_exp = sb.pop_front();
        chk("o_inst", o_inst, mon_exp[31:0]);
        chk("o_err", {31'b0, o_err}, {31'b0, mon_exp[32]});
      end
    end
  end

  // Entered and left at 1 time unit after a rising edge
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] ei, input logic ee);
    int n = 0;
    i_fmt = f; i_opcode = op; i_funct3 = f3; i_funct7 = f7;
    i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_valid = 1'b1;
    @(negedge i_clk);
    while (!o_ready && n < 64) begin
      @(posedge i_clk); #1; @(negedge i_clk); n++;
    end
    if (n >= 64) chk("accept_timeout", {31'b0, o_ready}, 32'd1);
    else sb.push_back({ee, ei});
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || o_valid) && n < 200) begin
      @(posedge i_clk); #1; n++;
    end
    chk("drain_timeout", {31'b0, o_valid}, 32'd0);
    chk("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge i_clk);
    chk("rst_o_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_o_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_o_inst", o_inst, 32'd0);
    chk("rst_o_err", {31'b0, o_err}, 32'd0);
    chk("rst_cnt_ok", {16'b0, o_cnt_ok}, 32'd0);
    chk("rst_cnt_err", {16'b0, o_cnt_err}, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("post_rst_o_ready", {31'b0, o_ready}, 32'd1);
    chk("post_rst_o_valid", {31'b0, o_valid}, 32'd0);
    @(posedge i_clk); #1;

    // addi x1, x0, 5 with latency probe
    send(3'd1, 7'h13, 3'd0, 7'h55, 5'd1, 5'd0, 5'd9, 32'd5, 32'h0050_0093, 1'b0);
    @(negedge i_clk);
    chk("lat_cycle1_valid", {31'b0, o_valid}, 32'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("lat_cycle2_valid", {31'b0, o_valid}, 32'd1);
    chk("lat_cycle2_inst", o_inst, 32'h0050_0093);
    @(posedge i_clk); #1;

    send(3'd4, 7'h37, 3'd7, 7'h7F, 5'd5, 5'd3, 5'd4, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send(3'd5, 7'h6F, 3'd2, 7'h11, 5'd1, 5'd7, 5'd8, 32'hFFFF_FFFC, 32'hFFDF_F0EF, 1'b0);

    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0000_0013, 1'b1);
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0000_0013, 1'b1);
    send(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0000_0013, 1'b1);
    drain();
    chk("cnt_err_3", {16'b0, o_cnt_err}, 32'd3);
    chk("cnt_ok_3", {16'b0, o_cnt_ok}, 32'd3);

    // legal encodings and range boundaries; unused fields carry junk
    send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
    send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'h1234_5678, 32'h4020_81B3, 1'b0);
    send(3'd2, 7'h23, 3'd2, 7'h7F, 5'd31, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
    send(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'hFE20_AFA3, 1'b0);
    send(3'd3, 7'h63, 3'd0, 7'h3C, 5'd17, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094, 32'h7E00_0FE3, 1'b0);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd31, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2047, 32'h7FF0_0093, 1'b0);
    send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd2, 32'h0020_006F, 1'b0);
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4096, 32'h0000_0013, 1'b1);
    send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h0000_0013, 1'b1);
    send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0000_0013, 1'b1);
    send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'h0000_0013, 1'b1);
    send(3'd6, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0000_0013, 1'b1);
    send(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_F7FF, 32'h0000_0013, 1'b1);
    drain();
    chk("cnt_ok_12", {16'b0, o_cnt_ok}, 32'd12);
    chk("cnt_err_9", {16'b0, o_cnt_err}, 32'd9);

    // backpressure: two accepted, third held off while the output stays put
    i_ready = 1'b0;
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd1, 32'h0010_0113, 1'b0);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'd2, 32'h0020_0193, 1'b0);
    i_fmt = 3'd1; i_opcode = 7'h13; i_funct3 = 3'd0; i_rd = 5'd4; i_rs1 = 5'd0;
    i_imm = 32'd3; i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk("stall_o_ready", {31'b0, o_ready}, 32'd0);
      chk("stall_o_valid", {31'b0, o_valid}, 32'd1);
      chk("stall_o_inst", o_inst, 32'h0010_0113);
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 32'd3, 32'h0030_0213, 1'b0);
    drain();
    chk("cnt_ok_15", {16'b0, o_cnt_ok}, 32'd15);

    // reset with both stages full
    i_ready = 1'b0;
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd1, 32'h0010_0113, 1'b0);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'd2, 32'h0020_0193, 1'b0);
    chk("full_o_valid", {31'b0, o_valid}, 32'd1);
    chk("full_o_ready", {31'b0, o_ready}, 32'd0);
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_o_valid", {31'b0, o_valid}, 32'd0);
    chk("async_rst_o_ready", {31'b0, o_ready}, 32'd1);
    chk("async_rst_cnt_ok", {16'b0, o_cnt_ok}, 32'd0);
    chk("async_rst_cnt_err", {16'b0, o_cnt_err}, 32'd0);
    sb.delete();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("rerst_o_valid", {31'b0, o_valid}, 32'd0);
    chk("rerst_o_ready", {31'b0, o_ready}, 32'd1);
    @(posedge i_clk); #1;
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    drain();
    chk("rerst_cnt_ok", {16'b0, o_cnt_ok}, 32'd1);

    // fill the ok counter to its ceiling, then one more
    for (int k = 0; k < 65534; k++) begin
      logic [31:0] imm;
      imm = k & 32'h3FF;
      send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, imm,
           {imm[11:0], 20'h0_0093}, 1'b0);
    end
    drain();
    chk("cnt_ok_full", {16'b0, o_cnt_ok}, 32'h0000_FFFF);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    drain();
    chk("cnt_ok_sat", {16'b0, o_cnt_ok}, 32'h0000_FFFF);
    chk("cnt_err_sat", {16'b0, o_cnt_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
